branch_predictor: RTL and testbench

Fetch-stage branch predictor: a direct-mapped branch target buffer (BTB) plus a gshare pattern history table (PHT) of 2-bit saturating counters. Each cycle it supplies the predicted next PC for the current fetch PC. It is trained non-speculatively by the resolved branch/jump outcome from EX. It sits upstream of the hazard detection unit, which compares the actual outcome against the `pred_taken` carried down the pipeline and flushes IF/ID on a mispredict.

---
 rtl/branch_predictor_pkg.sv | 34 +++
 rtl/branch_predictor_if.sv | 30 +++
 rtl/branch_predictor_sat_counter2.sv | 22 ++
 rtl/branch_predictor.sv | 103 ++++++++++
 tb/tb_branch_predictor.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch predictor.
//   - 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - BTB entry struct (tag stored zero-extended to the widest possible tag)
//   - index/tag extraction helpers parameterised on the index width
package bp_pkg;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   // Widest tag occurs at the smallest table (IDX = 2): 32 - 2 - 2 = 28 bits.
   localparam int TAG_W = 28;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [31:0]      target;
      logic             uncond;
   } btb_entry_t;

   // Word index into the tables: pc[idx+1:2], returned zero-extended.
   function automatic logic [31:0] bp_index(input logic [31:0] pc, input int idx);
      return (pc >> 2) & ((32'd1 << idx) - 32'd1);
   endfunction

   // Tag: pc[31:idx+2], returned zero-extended to TAG_W.
   function automatic logic [TAG_W-1:0] bp_tag(input logic [31:0] pc, input int idx);
      logic [31:0] t;
      t = pc >> (idx + 2);
      return t[TAG_W-1:0];
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup and EX training bundle of the branch predictor.
//   master: fetch/EX side (drives current_pc and the update_* fields)
//   slave : the predictor (drives pred_taken, next_pc, pred_target)
// No handshake: the lookup is combinational every cycle and an update is a
// single-cycle update_en pulse, consumed on the rising edge it is high.
interface branch_predictor_if;
   logic [31:0] current_pc;
   logic        pred_taken;
   logic [31:0] next_pc;
   logic [31:0] pred_target;
   logic        update_en;
   logic [31:0] update_pc;
   logic [31:0] update_target;
   logic        update_taken;
   logic        update_is_branch;
   logic        update_is_jal;
   logic        update_is_jalr;

   modport master (
      output current_pc, update_en, update_pc, update_target,
             update_taken, update_is_branch, update_is_jal, update_is_jalr,
      input  pred_taken, next_pc, pred_target
   );

   modport slave (
      input  current_pc, update_en, update_pc, update_target,
             update_taken, update_is_branch, update_is_jal, update_is_jalr,
      output pred_taken, next_pc, pred_target
   );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Combinational next state of a 2-bit saturating counter.
//   state_i : current counter value
//   taken_i : 1 = count up (max ST), 0 = count down (min SNT)
//   state_o : next counter value
module sat_counter2
   import bp_pkg::*;
(
   input  logic [1:0] state_i,
   input  logic       taken_i,
   output logic [1:0] state_o
);

   always_comb begin
      state_o = state_i;
      if (taken_i) begin
         if (state_i != ST) state_o = state_i + 2'd1;
      end else begin
         if (state_i != SNT) state_o = state_i - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB + gshare PHT of 2-bit
// saturating counters, trained non-speculatively from EX.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   bp (slave)  : current_pc -> pred_taken/next_pc/pred_target (combinational),
//                 update_* training pulse from EX
//   dbg_ghr_o   : current global history register
//   dbg_pht_o   : all PHT counters, entry i at [2*i +: 2]
module branch_predictor
   import bp_pkg::*;
#(
   parameter int ENTRIES  = 32,
   parameter int GHR_BITS = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   branch_predictor_if.slave      bp,
   output logic [GHR_BITS-1:0]    dbg_ghr_o,
   output logic [2*ENTRIES-1:0]   dbg_pht_o
);

   localparam int IDX = $clog2(ENTRIES);

   btb_entry_t          btb_q [ENTRIES];
   logic [1:0]          pht_q [ENTRIES];
   logic [GHR_BITS-1:0] ghr_q;
   logic [GHR_BITS-1:0] ghr_d;

   // ---------------- lookup ----------------
   logic [IDX-1:0]   l_bidx;
   logic [IDX-1:0]   l_pidx;
   logic [TAG_W-1:0] l_tag;
   btb_entry_t       l_ent;
   logic             l_hit;

   assign l_bidx = IDX'(bp_index(bp.current_pc, IDX));
   assign l_pidx = l_bidx ^ IDX'(ghr_q);
   assign l_tag  = bp_tag(bp.current_pc, IDX);
   assign l_ent  = btb_q[l_bidx];
   assign l_hit  = l_ent.valid && (l_ent.tag == l_tag);

   assign bp.pred_taken  = l_hit && (l_ent.uncond || pht_q[l_pidx][1]);
   assign bp.pred_target = l_hit ? l_ent.target : 32'd0;
   // +4 wraps naturally modulo 2^32.
   assign bp.next_pc     = bp.pred_taken ? l_ent.target : (bp.current_pc + 32'd4);

   // ---------------- update ----------------
   logic [IDX-1:0]   u_bidx;
   logic [IDX-1:0]   u_pidx;
   logic [TAG_W-1:0] u_tag;
   logic             u_match;
   logic [1:0]       pht_d;

   assign u_bidx  = IDX'(bp_index(bp.update_pc, IDX));
   assign u_pidx  = u_bidx ^ IDX'(ghr_q);
   assign u_tag   = bp_tag(bp.update_pc, IDX);
   assign u_match = btb_q[u_bidx].valid && (btb_q[u_bidx].tag == u_tag);

   sat_counter2 u_sat (
      .state_i (pht_q[u_pidx]),
      .taken_i (bp.update_taken),
      .state_o (pht_d)
   );

   // Shift in the outcome; the cast drops the oldest bit.
   assign ghr_d = GHR_BITS'({ghr_q, bp.update_taken});

   // Type flags are expected one-hot; if several are set, branch wins over
   // jal, and jal over jalr.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb_q[i] <= '0;
            pht_q[i] <= WNT;
         end
         ghr_q <= '0;
      end else if (bp.update_en) begin
         if (bp.update_is_branch) begin
            pht_q[u_pidx] <= pht_d;
            ghr_q         <= ghr_d;
            if (bp.update_taken) begin
               btb_q[u_bidx] <= '{valid: 1'b1, tag: u_tag,
                                  target: bp.update_target, uncond: 1'b0};
            end
         end else if (bp.update_is_jal) begin
            btb_q[u_bidx] <= '{valid: 1'b1, tag: u_tag,
                               target: bp.update_target, uncond: 1'b1};
         end else if (bp.update_is_jalr) begin
            // jalr targets are data dependent: drop any entry for this PC.
            if (u_match) btb_q[u_bidx].valid <= 1'b0;
         end
      end
   end

   // ---------------- debug ----------------
   assign dbg_ghr_o = ghr_q;

   always_comb begin
      dbg_pht_o = '0;
      for (int i = 0; i < ENTRIES; i++) dbg_pht_o[2*i +: 2] = pht_q[i];
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios followed by random training
// and lookups, checked against a table-level reference model.
module tb_branch_predictor;

   localparam int ENT = 32;
   localparam int GB  = 5;
   localparam int IDXB = 5;
   localparam int EW  = GB + 1 + 32 + 32;

   logic clk = 1'b0;
   logic reset;
   logic [GB-1:0]    dbg_ghr;
   logic [2*ENT-1:0] dbg_pht;
   logic look_v;

   int checks = 0;
   int errors = 0;

   logic [EW-1:0] exp_q[$];

   branch_predictor_if bp_if ();

   branch_predictor #(.ENTRIES(ENT), .GHR_BITS(GB)) dut (
      .clk       (clk),
      .reset     (reset),
      .bp        (bp_if),
      .dbg_ghr_o (dbg_ghr),
      .dbg_pht_o (dbg_pht)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   bit          m_valid  [ENT];
   int unsigned m_tag    [ENT];
   logic [31:0] m_tgt    [ENT];
   bit          m_uncond [ENT];
   int          m_cnt    [ENT];
   int unsigned m_ghr;

   function automatic void model_reset();
      for (int i = 0; i < ENT; i++) begin
         m_valid[i] = 0;
         m_cnt[i]   = 1;
      end
      m_ghr = 0;
   endfunction

   function automatic logic [EW-1:0] model_lookup(logic [31:0] pc);
      int unsigned i, t, p;
      bit hit, tk;
      logic [31:0] tgt, nxt;
      i   = (pc / 4) % ENT;
      t   = pc / (4 * ENT);
      p   = i ^ m_ghr;
      hit = m_valid[i] && (m_tag[i] == t);
      tk  = hit && (m_uncond[i] || m_cnt[p] >= 2);
      tgt = hit ? m_tgt[i] : 32'd0;
      nxt = tk ? tgt : pc + 32'd4;
      return {GB'(m_ghr), tk, tgt, nxt};
   endfunction

   function automatic void model_update(logic [31:0] pc, logic [31:0] tgt,
                                        bit tk, bit br, bit jal, bit jalr);
      int unsigned i, t, p;
      i = (pc / 4) % ENT;
      t = pc / (4 * ENT);
      p = i ^ m_ghr;
      if (br) begin
         if (tk) m_cnt[p] = (m_cnt[p] == 3) ? 3 : m_cnt[p] + 1;
         else    m_cnt[p] = (m_cnt[p] == 0) ? 0 : m_cnt[p] - 1;
         m_ghr = ((m_ghr * 2) + (tk ? 1 : 0)) % (1 << GB);
         if (tk) begin
            m_valid[i] = 1; m_tag[i] = t; m_tgt[i] = tgt; m_uncond[i] = 0;
         end
      end else if (jal) begin
         m_valid[i] = 1; m_tag[i] = t; m_tgt[i] = tgt; m_uncond[i] = 1;
      end else if (jalr) begin
         if (m_valid[i] && m_tag[i] == t) m_valid[i] = 0;
      end
   endfunction

   // ---------------- driver tasks ----------------
   // Called #1 after a rising edge; returns #1 after the next rising edge.
   task automatic step(input logic [31:0] lpc, input bit look, input bit en,
                       input logic [31:0] upc, input logic [31:0] utgt,
                       input bit tk, input bit br, input bit jal, input bit jalr);
      bp_if.current_pc       = lpc;
      bp_if.update_en        = en;
      bp_if.update_pc        = upc;
      bp_if.update_target    = utgt;
      bp_if.update_taken     = tk;
      bp_if.update_is_branch = br;
      bp_if.update_is_jal    = jal;
      bp_if.update_is_jalr   = jalr;
      look_v = look;
      if (look) exp_q.push_back(model_lookup(lpc));
      @(posedge clk);
      if (en) model_update(upc, utgt, tk, br, jal, jalr);
      #1;
      look_v = 1'b0;
      bp_if.update_en = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] pc);
      step(pc, 1, 0, 32'd0, 32'd0, 0, 0, 0, 0);
   endtask

   task automatic branch(input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
      step(32'd0, 0, 1, pc, tgt, tk, 1, 0, 0);
   endtask

   task automatic do_reset(input bit with_update);
      reset = 1'b1;
      bp_if.update_en        = with_update;
      bp_if.update_pc        = 32'h80;
      bp_if.update_target    = 32'h20;
      bp_if.update_taken     = 1'b1;
      bp_if.update_is_branch = 1'b1;
      bp_if.update_is_jal    = 1'b0;
      bp_if.update_is_jalr   = 1'b0;
      @(posedge clk);
      model_reset();
      #1;
      reset = 1'b0;
      bp_if.update_en = 1'b0;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_state(input string name);
      for (int i = 0; i < ENT; i++)
         check($sformatf("%s pht[%0d]", name, i), 32'(dbg_pht[2*i +: 2]), 32'(m_cnt[i]));
      check({name, " ghr"}, 32'(dbg_ghr), m_ghr);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (look_v) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL lookup: DUT output with no expected entry pc=0x%08h", bp_if.current_pc);
         end else begin
            logic [EW-1:0] e, a;
            e = exp_q.pop_front();
            a = {dbg_ghr, bp_if.pred_taken, bp_if.pred_target, bp_if.next_pc};
            if (a !== e) begin
               errors++;
               $display("FAIL lookup pc=0x%08h: got ghr=%0d taken=%0b target=0x%08h next=0x%08h expected ghr=%0d taken=%0b target=0x%08h next=0x%08h",
                        bp_if.current_pc, a[EW-1 -: GB], a[64], a[63:32], a[31:0],
                        e[EW-1 -: GB], e[64], e[63:32], e[31:0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1;
      look_v = 1'b0;
      bp_if.current_pc = '0;
      bp_if.update_en = 1'b0;
      bp_if.update_pc = '0;
      bp_if.update_target = '0;
      bp_if.update_taken = 1'b0;
      bp_if.update_is_branch = 1'b0;
      bp_if.update_is_jal = 1'b0;
      bp_if.update_is_jalr = 1'b0;
      @(posedge clk);
      @(posedge clk);
      model_reset();
      #1;
      reset = 1'b0;

      // Reset state
      check_state("reset");
      lookup(32'h0);
      check("reset next_pc 0x0", bp_if.next_pc, 32'h4);
      lookup(32'h100);
      lookup(32'hFFFF_FFFC);
      check("wrap next_pc", bp_if.next_pc, 32'h0);

      // jal allocation
      step(32'h40, 1, 1, 32'h40, 32'h200, 1, 0, 1, 0);  // same-cycle lookup sees old state
      lookup(32'h40);
      check_state("after jal");

      // Branch training at 0x80 with GHR restored between updates
      branch(32'h80, 32'h20, 1);
      for (int k = 0; k < GB; k++) branch(32'h0C, 32'h0, 0);
      branch(32'h80, 32'h20, 1);
      for (int k = 0; k < GB; k++) branch(32'h0C, 32'h0, 0);
      check("pht[0] saturate up", 32'(dbg_pht[1:0]), 32'd3);
      lookup(32'h80);
      for (int k = 0; k < 4; k++) begin
         branch(32'h80, 32'h20, 0);
         lookup(32'h80);
      end
      check("pht[0] saturate down", 32'(dbg_pht[1:0]), 32'd0);
      check_state("after training");

      // Aliasing: same index, different tag
      branch(32'h80, 32'h300, 1);
      branch(32'h1080, 32'h400, 1);
      lookup(32'h80);
      lookup(32'h1080);

      // jalr invalidates matching entry only
      step(32'h0, 0, 1, 32'h40, 32'h200, 1, 0, 1, 0);
      step(32'h0, 0, 1, 32'h1040, 32'h0, 1, 0, 0, 1);  // tag mismatch: keep
      lookup(32'h40);
      step(32'h0, 0, 1, 32'h40, 32'h0, 1, 0, 0, 1);
      lookup(32'h40);
      check("jalr invalidate next_pc", bp_if.next_pc, 32'h44);

      // Update with no type flag: no effect
      step(32'h0, 0, 1, 32'h80, 32'h500, 1, 0, 0, 0);
      lookup(32'h80);
      check_state("no-flag update");

      // Reset wins over same-cycle update
      do_reset(1);
      check_state("reset with update");
      lookup(32'h80);
      lookup(32'h1080);

      // Random phase
      for (int n = 0; n < 600; n++) begin
         logic [31:0] lpc, upc, tgt;
         int r;
         lpc = (32'($urandom_range(0, 2)) << (IDXB + 2)) | (32'($urandom_range(0, 7)) << 2);
         upc = (32'($urandom_range(0, 2)) << (IDXB + 2)) | (32'($urandom_range(0, 7)) << 2);
         tgt = $urandom & 32'hFFFF_FFFC;
         r = $urandom_range(0, 9);
         if ($urandom_range(0, 99) == 0) begin
            do_reset($urandom_range(0, 1) == 1);
         end else begin
            step(lpc, 1, $urandom_range(0, 9) < 7, upc, tgt, $urandom_range(0, 1) == 1,
                 r <= 5, r == 6 || r == 7, r == 8);
         end
         if (n % 100 == 99) check_state("random");
      end

      // Drain scoreboard, bounded
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected lookups never observed, required 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
